// File: rtl/regfile_port_sched.sv
// regfile_port_sched: owns the regfile write port; init sweep after reset/reinit, then core/debug arbitration with a starvation guard.
module regfile_port_sched #(
  parameter int W          = 64,
  parameter int NREG       = 32,
  parameter int ZERO_REG   = 31,
  parameter int INIT_ZERO  = 0,
  parameter int STARVE_LIM = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reinit,
  input  logic                    core_we,
  input  logic [$clog2(NREG)-1:0] core_wa,
  input  logic [W-1:0]            core_wd,
  input  logic                    dbg_valid,
  input  logic [$clog2(NREG)-1:0] dbg_wa,
  input  logic [W-1:0]            dbg_wd,
  output logic                    dbg_ready,
  output logic                    core_stall,
  output logic                    init_busy,
  output logic                    rf_we3,
  output logic [$clog2(NREG)-1:0] rf_wa3,
  output logic [W-1:0]            rf_wd3
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic INIT = 1'b0;
  localparam logic RUN  = 1'b1;
  logic          state;
  logic [AW-1:0] icnt;
  logic [CW-1:0] wcnt;
  logic          run, forced, rdy, dbg_go, core_go;
  logic [AW-1:0] wa;
  logic [W-1:0]  wd;
  always_comb begin
    run        = state == RUN;
    forced     = run && dbg_valid && wcnt == CW'(STARVE_LIM);
    rdy        = run && (forced || !core_we);
    dbg_go     = rdy && dbg_valid;
    core_go    = run && core_we && !forced;
    wa         = run ? (dbg_go ? dbg_wa : core_wa) : icnt;
    wd         = run ? (dbg_go ? dbg_wd : core_wd) : (INIT_ZERO != 0 ? '0 : W'(icnt));
    rf_we3     = !reset && (!run || ((dbg_go || core_go) && wa != AW'(ZERO_REG)));
    rf_wa3     = reset ? '0 : wa;
    rf_wd3     = reset ? '0 : wd;
    dbg_ready  = !reset && rdy;
    core_stall = reset || !run || forced;
    init_busy  = reset || !run;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      icnt  <= '0;
      wcnt  <= '0;
    end else if (!run) begin
      icnt  <= icnt == AW'(NREG - 2) ? '0 : icnt + AW'(1);
      state <= icnt == AW'(NREG - 2) ? RUN : INIT;
      wcnt  <= '0;
    end else if (reinit) begin
      state <= INIT;
      icnt  <= '0;
      wcnt  <= '0;
    end else begin
      wcnt  <= (!dbg_valid || rdy) ? '0 : wcnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_regfile_port_sched.sv
// tb_regfile_port_sched: vector table plus write scoreboard for regfile_port_sched.
module tb_regfile_port_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1, reinit = 1'b0, core_we = 1'b0, dbg_valid = 1'b0;
  logic [4:0]  core_wa = '0, dbg_wa = '0;
  logic [63:0] core_wd = '0, dbg_wd = '0;
  logic        dbg_ready, core_stall, init_busy, rf_we3;
  logic [4:0]  rf_wa3;
  logic [63:0] rf_wd3;
  always #5 clk = ~clk;
  regfile_port_sched dut (
    .clk(clk), .reset(reset), .reinit(reinit),
    .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd),
    .dbg_valid(dbg_valid), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd),
    .dbg_ready(dbg_ready), .core_stall(core_stall), .init_busy(init_busy),
    .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3)
  );
  typedef struct {
    logic rst, ri, cwe;
    logic [4:0] cwa;
    logic [63:0] cwd;
    logic dv;
    logic [4:0] dwa;
    logic [63:0] dwd;
    logic e_we;
    logic [4:0] e_wa;
    logic [63:0] e_wd;
    logic e_rdy, e_st, e_busy;
  } vec_t;
  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
  } wr_t;
  wr_t  sb[$];
  vec_t tbl[$];
  int   n_chk = 0, n_pass = 0;
  function automatic vec_t mk(input logic rst, ri, cwe, input logic [4:0] cwa, input logic [63:0] cwd,
                              input logic dv, input logic [4:0] dwa, input logic [63:0] dwd,
                              input logic e_we, input logic [4:0] e_wa, input logic [63:0] e_wd,
                              input logic e_rdy, e_st, e_busy);
    vec_t v;
    v.rst = rst; v.ri = ri; v.cwe = cwe; v.cwa = cwa; v.cwd = cwd;
    v.dv = dv; v.dwa = dwa; v.dwd = dwd;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_rdy = e_rdy; v.e_st = e_st; v.e_busy = e_busy;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic apply(input vec_t v, input string tag);
    wr_t e;
    @(negedge clk);
    reset = v.rst; reinit = v.ri;
    core_we = v.cwe; core_wa = v.cwa; core_wd = v.cwd;
    dbg_valid = v.dv; dbg_wa = v.dwa; dbg_wd = v.dwd;
    if (v.e_we) sb.push_back('{v.e_wa, v.e_wd});
    #1;
    chk({tag, " we3"}, 64'(rf_we3), 64'(v.e_we));
    chk({tag, " dbg_ready"}, 64'(dbg_ready), 64'(v.e_rdy));
    chk({tag, " core_stall"}, 64'(core_stall), 64'(v.e_st));
    chk({tag, " init_busy"}, 64'(init_busy), 64'(v.e_busy));
    if (rf_we3 && sb.size() == 0) chk({tag, " unexpected write"}, 64'(rf_we3), 64'd0);
    else if (rf_we3) begin
      e = sb.pop_front();
      chk({tag, " wa3"}, 64'(rf_wa3), 64'(e.wa));
      chk({tag, " wd3"}, rf_wd3, e.wd);
    end
    if (sb.size() != 0) begin
      chk({tag, " missing write"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    if (v.rst) begin
      chk({tag, " reset wa3"}, 64'(rf_wa3), 64'd0);
      chk({tag, " reset wd3"}, rf_wd3, 64'd0);
    end
  endtask
  task automatic init_sweep(input string tag, input int n);
    for (int i = 0; i < n; i++)
      apply(mk(1'b0, i == 15, 1'b1, 5'(i + 1), 64'hBAD, 1'b1, 5'(i + 2), 64'hBEEF,
               1'b1, 5'(i), 64'(i), 1'b0, 1'b1, 1'b1), tag);
  endtask
  vec_t rstv, idle;
  initial begin
    rstv = mk(1'b1, 1'b0, 1'b1, 5'd3, 64'h77, 1'b1, 5'd4, 64'h88, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    idle = mk(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    apply(rstv, "reset0");
    apply(rstv, "reset1");
    init_sweep("init1", 31);
    apply(idle, "init1 done");
    tbl.push_back(mk(0, 0, 1, 5'd5, 64'hAA, 1, 5'd6, 64'h66, 1, 5'd5, 64'hAA, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5'd0, 64'h0, 1, 5'd6, 64'h66, 1, 5'd6, 64'h66, 1, 0, 0));
    tbl.push_back(idle);
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 1, 5'(8 + k), 64'(256 + k), 1, 5'd7, 64'h55, 1, 5'(8 + k), 64'(256 + k), 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5'd12, 64'h200, 1, 5'd7, 64'h55, 1, 5'd7, 64'h55, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 5'd13, 64'h300, 0, 5'd0, 64'h0, 1, 5'd13, 64'h300, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 0, 1, 5'(14 + k), 64'(1024 + k), 1, 5'd9, 64'h99, 1, 5'(14 + k), 64'(1024 + k), 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5'd17, 64'h400, 0, 5'd9, 64'h99, 1, 5'd17, 64'h400, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 1, 5'(18 + k), 64'(2048 + k), 1, 5'd9, 64'h99, 1, 5'(18 + k), 64'(2048 + k), 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5'd22, 64'h500, 1, 5'd9, 64'h99, 1, 5'd9, 64'h99, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 5'd31, 64'hFF, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5'd0, 64'h0, 1, 5'd31, 64'hFF, 0, 5'd0, 64'h0, 1, 0, 0));
    tbl.push_back(idle);
    foreach (tbl[i]) apply(tbl[i], $sformatf("run%0d", i));
    apply(rstv, "midreset0");
    init_sweep("partial", 10);
    apply(rstv, "midreset1");
    init_sweep("init2", 31);
    apply(idle, "init2 done");
    apply(mk(0, 1, 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 5'd3, 64'h33, 0, 0, 0), "reinit");
    init_sweep("init3", 31);
    apply(idle, "init3 done");
    apply(mk(0, 0, 1, 5'd4, 64'h44, 0, 5'd0, 64'h0, 1, 5'd4, 64'h44, 0, 0, 0), "post core");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
